// File: rtl/fpu_issue.sv
// Issue/writeback controller in front of the fpu: queues decoded float ops, runs them one
// at a time through the fpu, and hands each result to the register-file writeback port.
module fpu_issue #(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        issue_valid_i,
    output logic        issue_ready_o,
    input  logic [4:0]  issue_op_i,
    input  logic [3:0]  issue_rd_i,
    input  logic [15:0] issue_a_i,
    input  logic [15:0] issue_b_i,
    output logic        illegal_o,
    output logic        fpu_en_o,
    output logic [4:0]  fpu_instr_o,
    output logic [15:0] fpu_op1_o,
    output logic [15:0] fpu_op2_o,
    input  logic        fpu_done_i,
    input  logic [15:0] fpu_result_i,
    output logic        wb_valid_o,
    input  logic        wb_ready_i,
    output logic [3:0]  wb_rd_o,
    output logic [15:0] wb_data_o,
    output logic        timeout_o
);
    localparam int unsigned PtrW    = $clog2(DEPTH);
    localparam logic [PtrW:0] Full  = (PtrW + 1)'(DEPTH);
    localparam logic [7:0] LastCnt  = 8'(TIMEOUT - 1);

    typedef struct packed {
        logic [4:0]  op;
        logic [3:0]  rd;
        logic [15:0] a;
        logic [15:0] b;
    } entry_t;

    typedef enum logic [1:0] {StIdle, StArm, StWait, StWb} state_e;

    entry_t          mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q;
    state_e          state_q;
    logic [7:0]      cnt_q;
    logic [3:0]      rd_q;
    logic            fpu_en_q, wb_valid_q, illegal_q, timeout_q;
    logic [4:0]      instr_q;
    logic [15:0]     op1_q, op2_q, wb_data_q;
    logic [3:0]      wb_rd_q;

    logic   legal, full, empty, accept, pop, bypass, enq, launch;
    entry_t in_entry, launch_entry;

    always_comb begin
        legal    = (issue_op_i >= 5'h11) && (issue_op_i <= 5'h16);
        full     = (count_q == Full);
        empty    = (count_q == '0);
        accept   = issue_valid_i && !full && legal;
        in_entry = {issue_op_i, issue_rd_i, issue_a_i, issue_b_i};
        pop      = !empty && ((state_q == StIdle) || ((state_q == StWb) && wb_ready_i));
        // An op arriving at an idle, empty controller skips the queue entirely.
        bypass       = empty && accept && (state_q == StIdle);
        enq          = accept && !bypass;
        launch       = pop || bypass;
        launch_entry = pop ? mem_q[rd_ptr_q] : in_entry;
    end

    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wr_ptr_q] <= in_entry;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (enq) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (enq && !pop)      count_q <= count_q + (PtrW + 1)'(1);
            else if (!enq && pop) count_q <= count_q - (PtrW + 1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            rd_q       <= '0;
            fpu_en_q   <= 1'b0;
            instr_q    <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            illegal_q <= issue_valid_i && !legal;
            if (launch) begin
                instr_q <= launch_entry.op;
                rd_q    <= launch_entry.rd;
                op1_q   <= launch_entry.a;
                op2_q   <= launch_entry.b;
            end
            unique case (state_q)
                StIdle: begin
                    if (launch) begin
                        fpu_en_q <= 1'b1;
                        state_q  <= StArm;
                    end
                end
                // Done is ignored here: the fpu drops any stale done on this edge.
                StArm: begin
                    cnt_q   <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    if (fpu_done_i) begin
                        wb_data_q  <= fpu_result_i;
                        wb_rd_q    <= rd_q;
                        wb_valid_q <= 1'b1;
                        fpu_en_q   <= 1'b0;
                        state_q    <= StWb;
                    end else if (cnt_q == LastCnt) begin
                        fpu_en_q  <= 1'b0;
                        timeout_q <= 1'b1;
                        state_q   <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StWb: begin
                    if (wb_ready_i) begin
                        wb_valid_q <= 1'b0;
                        if (launch) begin
                            fpu_en_q <= 1'b1;
                            state_q  <= StArm;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign issue_ready_o = !full;
    assign illegal_o     = illegal_q;
    assign fpu_en_o      = fpu_en_q;
    assign fpu_instr_o   = instr_q;
    assign fpu_op1_o     = op1_q;
    assign fpu_op2_o     = op2_q;
    assign wb_valid_o    = wb_valid_q;
    assign wb_rd_o       = wb_rd_q;
    assign wb_data_o     = wb_data_q;
    assign timeout_o     = timeout_q;
endmodule

// File: tb/tb_fpu_issue.sv
// Bench for fpu_issue with a stub fpu of programmable latency (ITOF -> bfloat16, else op1^op2).
module tb_fpu_issue;
    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid, issue_ready;
    logic [4:0]  issue_op;
    logic [3:0]  issue_rd;
    logic [15:0] issue_a, issue_b;
    logic        illegal, fpu_en;
    logic [4:0]  fpu_instr;
    logic [15:0] fpu_op1, fpu_op2;
    logic        stub_done;
    logic [15:0] stub_res;
    logic        wb_valid, wb_ready;
    logic [3:0]  wb_rd;
    logic [15:0] wb_data;
    logic        timeout;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fpu_issue #(.DEPTH(2), .TIMEOUT(64)) dut (
        .clk_i(clk), .reset_i(reset),
        .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
        .issue_op_i(issue_op), .issue_rd_i(issue_rd), .issue_a_i(issue_a), .issue_b_i(issue_b),
        .illegal_o(illegal), .fpu_en_o(fpu_en), .fpu_instr_o(fpu_instr),
        .fpu_op1_o(fpu_op1), .fpu_op2_o(fpu_op2),
        .fpu_done_i(stub_done), .fpu_result_i(stub_res),
        .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
        .timeout_o(timeout)
    );

    // Stub fpu: latency 0 means done never rises.
    int   stub_lat;
    int   stub_cnt;
    logic en_prev;
    logic stale_req;

    function automatic logic [15:0] itof(input logic [15:0] v);
        int m;
        logic [15:0] mant;
        m = -1;
        for (int i = 0; i < 16; i++) if (v[i]) m = i;
        if (m < 0) return 16'h0000;
        mant = (m <= 7) ? (v << (7 - m)) : (v >> (m - 7));
        return {1'b0, 8'(127 + m), mant[6:0]};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            stub_done <= 1'b0;
            stub_res  <= 16'h0000;
            en_prev   <= 1'b0;
            stub_cnt  <= 0;
        end else begin
            en_prev <= fpu_en;
            if (stale_req) begin
                stub_done <= 1'b1;
                stub_res  <= 16'hDEAD;
            end else if (fpu_en && !en_prev) begin
                stub_done <= 1'b0;
                stub_cnt  <= 1;
            end else if (fpu_en && !stub_done && stub_lat > 0) begin
                if (stub_cnt >= stub_lat) begin
                    stub_done <= 1'b1;
                    stub_res  <= (fpu_instr == 5'h13) ? itof(fpu_op2) : (fpu_op1 ^ fpu_op2);
                end
                stub_cnt <= stub_cnt + 1;
            end
        end
    end

    typedef struct {
        logic [3:0]  rd;
        logic [15:0] d;
    } wb_t;
    wb_t log_q[$];

    always begin
        @(negedge clk);
        #4;
        if (wb_valid && wb_ready) log_q.push_back('{wb_rd, wb_data});
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_op(input logic [4:0] op, input logic [3:0] rd, input logic [15:0] a,
                          input logic [15:0] b);
        issue_valid = 1'b1;
        issue_op    = op;
        issue_rd    = rd;
        issue_a     = a;
        issue_b     = b;
    endtask

    task automatic wait_log(input int n, input int bound);
        int k = 0;
        while (log_q.size() < n && k < bound) begin
            @(negedge clk);
            #3;
            k++;
        end
    endtask

    task automatic chk_wb(input string nm, input int idx, input logic [3:0] rd,
                          input logic [15:0] d);
        if (log_q.size() > idx) begin
            chk({nm, "_rd"}, log_q[idx].rd, rd);
            chk({nm, "_data"}, log_q[idx].d, d);
        end else begin
            chk({nm, "_present"}, log_q.size(), idx + 1);
        end
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [3:0]  rd;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
        logic        bad;
    } vec_t;
    localparam int NV = 10;
    vec_t vec [NV];

    initial begin
        int k, acc, rdy;
        logic seen;

        vec[0] = '{5'h13, 4'd3,  16'h0000, 16'h0007, 16'h40E0, 1'b0};
        vec[1] = '{5'h11, 4'd5,  16'h1234, 16'h00FF, 16'h12CB, 1'b0};
        vec[2] = '{5'h16, 4'd15, 16'hFFFF, 16'h0F0F, 16'hF0F0, 1'b0};
        vec[3] = '{5'h08, 4'd1,  16'hAAAA, 16'h5555, 16'h0000, 1'b1};
        vec[4] = '{5'h14, 4'd0,  16'hA5A5, 16'h5A5A, 16'hFFFF, 1'b0};
        vec[5] = '{5'h13, 4'd9,  16'h0000, 16'h0001, 16'h3F80, 1'b0};
        vec[6] = '{5'h17, 4'd2,  16'h0001, 16'h0001, 16'h0000, 1'b1};
        vec[7] = '{5'h12, 4'd4,  16'h00F0, 16'h000F, 16'h00FF, 1'b0};
        vec[8] = '{5'h13, 4'd2,  16'h0000, 16'h0064, 16'h42C8, 1'b0};
        vec[9] = '{5'h10, 4'd6,  16'h0000, 16'h0000, 16'h0000, 1'b1};

        reset = 1'b1; issue_valid = 1'b0; issue_op = '0; issue_rd = '0;
        issue_a = '0; issue_b = '0; wb_ready = 1'b1; stub_lat = 2; stale_req = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_issue_ready", issue_ready, 1);
        chk("rst_fpu_en", fpu_en, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_fpu_instr", fpu_instr, 0);

        // Single-op vectors.
        for (int i = 0; i < NV; i++) begin
            log_q.delete();
            set_op(vec[i].op, vec[i].rd, vec[i].a, vec[i].b);
            @(negedge clk);
            issue_valid = 1'b0;
            if (vec[i].bad) begin
                chk($sformatf("v%0d_illegal", i), illegal, 1);
                chk($sformatf("v%0d_no_launch", i), fpu_en, 0);
                @(negedge clk);
                chk($sformatf("v%0d_illegal_clr", i), illegal, 0);
                repeat (15) @(negedge clk);
                #3;
                chk($sformatf("v%0d_no_wb", i), log_q.size(), 0);
                chk($sformatf("v%0d_ready", i), issue_ready, 1);
            end else begin
                chk($sformatf("v%0d_launch_en", i), fpu_en, 1);
                chk($sformatf("v%0d_launch_instr", i), fpu_instr, vec[i].op);
                chk($sformatf("v%0d_no_illegal", i), illegal, 0);
                wait_log(1, 60);
                repeat (3) @(negedge clk);
                #3;
                chk($sformatf("v%0d_wb_count", i), log_q.size(), 1);
                chk_wb($sformatf("v%0d", i), 0, vec[i].rd, vec[i].exp);
            end
        end

        // Three ops back to back, latency 5.
        @(negedge clk);
        log_q.delete();
        stub_lat = 5;
        acc = 0; k = 0;
        set_op(5'h11, 4'd1, 16'h0001, 16'h0010);
        while (acc < 3 && k < 50) begin
            rdy = int'(issue_ready);
            @(negedge clk);
            k++;
            if (rdy != 0) acc++;
            case (acc)
                1: set_op(5'h14, 4'd2, 16'h0200, 16'h0002);
                2: set_op(5'h16, 4'd3, 16'h3000, 16'h0300);
                default: issue_valid = 1'b0;
            endcase
        end
        chk("b2b_accept_cycles", k, 3);
        chk("b2b_full_ready", issue_ready, 0);
        wait_log(3, 200);
        chk("b2b_wb_count", log_q.size(), 3);
        chk_wb("b2b0", 0, 4'd1, 16'h0011);
        chk_wb("b2b1", 1, 4'd2, 16'h0202);
        chk_wb("b2b2", 2, 4'd3, 16'h3300);

        // Stale done held high into the next op's ARM cycle.
        @(negedge clk);
        log_q.delete();
        stub_lat = 4;
        stale_req = 1'b1;
        @(negedge clk);
        stale_req = 1'b0;
        set_op(5'h11, 4'd8, 16'h0F0F, 16'h1111);
        @(negedge clk);
        issue_valid = 1'b0;
        wait_log(1, 60);
        repeat (3) @(negedge clk);
        #3;
        chk("stale_wb_count", log_q.size(), 1);
        chk_wb("stale", 0, 4'd8, 16'h1E1E);

        // Timeout with a second op queued behind.
        @(negedge clk);
        log_q.delete();
        stub_lat = 0;
        set_op(5'h14, 4'd10, 16'h0BAD, 16'h0001);
        @(negedge clk);
        chk("to_arm_en", fpu_en, 1);
        set_op(5'h16, 4'd11, 16'h00C0, 16'h0C00);
        @(negedge clk);
        issue_valid = 1'b0;
        k = 1;
        while (timeout !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("to_cycles_after_arm", k, 65);
        stub_lat = 3;
        @(negedge clk);
        chk("to_pulse_clr", timeout, 0);
        chk("to_next_launch_en", fpu_en, 1);
        chk("to_next_launch_op1", fpu_op1, 16'h00C0);
        #3;
        chk("to_no_wb", log_q.size(), 0);
        wait_log(1, 60);
        chk_wb("to_next", 0, 4'd11, 16'h0CC0);

        // Writeback stall with an op queued.
        @(negedge clk);
        log_q.delete();
        stub_lat = 3;
        wb_ready = 1'b0;
        set_op(5'h11, 4'd6, 16'h1111, 16'h2222);
        @(negedge clk);
        set_op(5'h16, 4'd7, 16'h4444, 16'h0004);
        @(negedge clk);
        issue_valid = 1'b0;
        k = 0;
        while (wb_valid !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        for (int j = 0; j < 10; j++) begin
            chk($sformatf("stall%0d_valid", j), wb_valid, 1);
            chk($sformatf("stall%0d_data", j), wb_data, 16'h3333);
            chk($sformatf("stall%0d_rd", j), wb_rd, 4'd6);
            chk($sformatf("stall%0d_fpu_en", j), fpu_en, 0);
            @(negedge clk);
        end
        wb_ready = 1'b1;
        @(negedge clk);
        chk("stall_accept_valid", wb_valid, 0);
        chk("stall_next_en", fpu_en, 1);
        chk("stall_next_op1", fpu_op1, 16'h4444);
        wait_log(2, 60);
        chk_wb("stall0", 0, 4'd6, 16'h3333);
        chk_wb("stall1", 1, 4'd7, 16'h4440);

        // Reset while waiting on the fpu, with another op queued.
        @(negedge clk);
        log_q.delete();
        stub_lat = 0;
        set_op(5'h14, 4'd12, 16'h0101, 16'h0202);
        @(negedge clk);
        set_op(5'h11, 4'd13, 16'h0303, 16'h0404);
        @(negedge clk);
        issue_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("rstmid_pre_en", fpu_en, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstmid_fpu_en", fpu_en, 0);
        chk("rstmid_wb_valid", wb_valid, 0);
        chk("rstmid_ready", issue_ready, 1);
        chk("rstmid_timeout", timeout, 0);
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (fpu_en || wb_valid || timeout) seen = 1'b1;
        end
        #3;
        chk("rstmid_flushed", seen, 0);
        chk("rstmid_no_wb", log_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
